q_bank_argmax: RTL and testbench

- Parametrised successor to the flat Q-value unpacker.
- Holds a registered bank of N_ROADS x N_ACTIONS signed Q-values written one road-row at a time, and exposes the whole bank as a flat vector.
- A sequential scanner finds, for a requested road, the maximum Q-value and its action index.
- Sits between the AXI register interface (row writes) and the action-selection logic (greedy policy).

---
 rtl/q_pkg.sv | 26 ++
 rtl/q_bank_argmax_if.sv | 37 +++
 rtl/q_argmax_scan.sv | 102 ++++++++++
 rtl/q_bank_argmax.sv | 66 ++++++
 tb/tb_q_bank_argmax.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/q_pkg.sv
// Shared definitions for the Q-value bank and its argmax scanner.
//   - QWidthDefault : default width of one signed Q-value
//   - idx_width()   : index width for a count, never narrower than 1 bit
//   - scan_state_e  : scanner FSM encoding (idle / scanning / result pulse)
//   - elem_lsb()    : bit offset of (road, action) inside a flattened bank
package q_pkg;

  localparam int unsigned QWidthDefault = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  function automatic int unsigned elem_lsb(input int unsigned road, input int unsigned action,
                                           input int unsigned n_actions,
                                           input int unsigned q_width);
    return (road * n_actions + action) * q_width;
  endfunction

endpackage

// File: rtl/q_bank_argmax_if.sv
// Bus between the row writer / scan requester (master) and the Q-value bank (slave).
//   wr_valid/wr_ready/wr_road/wr_data : row write handshake
//   start/scan_road                   : scan request
//   busy/done/max_q/max_action        : scan status and result
//   q_flat                            : whole bank, road-major, action-minor
interface q_bank_argmax_if import q_pkg::*; #(
  parameter int unsigned Q_WIDTH   = QWidthDefault,
  parameter int unsigned N_ACTIONS = 4,
  parameter int unsigned N_ROADS   = 4
) ();

  localparam int unsigned AW = idx_width(N_ACTIONS);
  localparam int unsigned RW = idx_width(N_ROADS);

  logic                               wr_valid;
  logic                               wr_ready;
  logic [RW-1:0]                      wr_road;
  logic [Q_WIDTH*N_ACTIONS-1:0]       wr_data;
  logic                               start;
  logic [RW-1:0]                      scan_road;
  logic                               busy;
  logic                               done;
  logic [Q_WIDTH-1:0]                 max_q;
  logic [AW-1:0]                      max_action;
  logic [Q_WIDTH*N_ACTIONS*N_ROADS-1:0] q_flat;

  modport master (
    output wr_valid, wr_road, wr_data, start, scan_road,
    input  wr_ready, busy, done, max_q, max_action, q_flat
  );

  modport slave (
    input  wr_valid, wr_road, wr_data, start, scan_road,
    output wr_ready, busy, done, max_q, max_action, q_flat
  );

endinterface

// File: rtl/q_argmax_scan.sv
// Sequential argmax over one packed row of signed Q-values, one element per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : scan request, honoured only when idle
//   scan_road_i   : road captured with start_i
//   road_o        : latched road, drives the row mux in the parent
//   row_i         : packed row of the latched road
//   busy_o/done_o : not idle / one-cycle result pulse
//   max_q_o, max_action_o : result, held until the next completed scan
module q_argmax_scan import q_pkg::*; #(
  parameter int unsigned Q_WIDTH   = QWidthDefault,
  parameter int unsigned N_ACTIONS = 4,
  parameter int unsigned N_ROADS   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [idx_width(N_ROADS)-1:0] scan_road_i,
  output logic [idx_width(N_ROADS)-1:0] road_o,
  input  logic [Q_WIDTH*N_ACTIONS-1:0] row_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [Q_WIDTH-1:0]           max_q_o,
  output logic [idx_width(N_ACTIONS)-1:0] max_action_o
);

  localparam int unsigned AW = idx_width(N_ACTIONS);
  localparam int unsigned RW = idx_width(N_ROADS);

  scan_state_e               state_q;
  logic [RW-1:0]             road_q;
  logic [AW-1:0]             ptr_q;
  logic [AW-1:0]             idx_q;
  logic [AW-1:0]             max_action_q;
  logic signed [Q_WIDTH-1:0] best_q;
  logic signed [Q_WIDTH-1:0] max_q_q;
  logic signed [Q_WIDTH-1:0] elem;
  logic signed [Q_WIDTH-1:0] cand_best;
  logic [AW-1:0]             cand_idx;
  logic                      last;

  always_comb begin
    elem = '0;
    for (int a = 0; a < N_ACTIONS; a++) begin
      if (ptr_q == AW'(a)) elem = row_i[elem_lsb(0, a, N_ACTIONS, Q_WIDTH) +: Q_WIDTH];
    end
  end

  // First element seeds the running best; later ones win only if strictly
  // greater, so ties keep the lowest index.
  always_comb begin
    cand_best = best_q;
    cand_idx  = idx_q;
    if ((ptr_q == '0) || (elem > best_q)) begin
      cand_best = elem;
      cand_idx  = ptr_q;
    end
  end

  assign last = (ptr_q == AW'(N_ACTIONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      road_q       <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      max_q_q      <= '0;
      max_action_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            road_q  <= scan_road_i;
            ptr_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          best_q <= cand_best;
          idx_q  <= cand_idx;
          ptr_q  <= ptr_q + 1'b1;
          if (last) begin
            ptr_q        <= '0;
            max_q_q      <= cand_best;
            max_action_q <= cand_idx;
            state_q      <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign road_o       = road_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign max_q_o      = max_q_q;
  assign max_action_o = max_action_q;

endmodule

// File: rtl/q_bank_argmax.sv
// Registered bank of N_ROADS x N_ACTIONS signed Q-values with a greedy argmax scanner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of q_bank_argmax_if (row writes, scan request/result, flat bank)
// Writes are refused while a scan runs so the scanned row stays stable.
module q_bank_argmax import q_pkg::*; #(
  parameter int unsigned Q_WIDTH   = QWidthDefault,
  parameter int unsigned N_ACTIONS = 4,
  parameter int unsigned N_ROADS   = 4
) (
  input  logic            clk,
  input  logic            rst,
  q_bank_argmax_if.slave  bus
);

  localparam int unsigned RW   = idx_width(N_ROADS);
  localparam int unsigned RowW = Q_WIDTH * N_ACTIONS;

  // Packed road-major, so the bank itself is already the q_flat layout.
  logic [N_ROADS-1:0][RowW-1:0] bank_q;
  logic [RowW-1:0]              scan_row;
  logic [RW-1:0]                scan_road_q;
  logic                         busy;
  logic                         wr_fire;

  assign bus.wr_ready = !busy;
  assign wr_fire      = bus.wr_valid && !busy;

  // An out-of-range road matches no row: handshake completes, bank untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else if (wr_fire) begin
      for (int r = 0; r < N_ROADS; r++) begin
        if (bus.wr_road == RW'(r)) bank_q[r] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    scan_row = '0;
    for (int r = 0; r < N_ROADS; r++) begin
      if (scan_road_q == RW'(r)) scan_row = bank_q[r];
    end
  end

  assign bus.q_flat = bank_q;
  assign bus.busy   = busy;

  q_argmax_scan #(
    .Q_WIDTH   (Q_WIDTH),
    .N_ACTIONS (N_ACTIONS),
    .N_ROADS   (N_ROADS)
  ) u_scan (
    .clk          (clk),
    .rst          (rst),
    .start_i      (bus.start),
    .scan_road_i  (bus.scan_road),
    .road_o       (scan_road_q),
    .row_i        (scan_row),
    .busy_o       (busy),
    .done_o       (bus.done),
    .max_q_o      (bus.max_q),
    .max_action_o (bus.max_action)
  );

endmodule

// File: tb/tb_q_bank_argmax.sv
// Directed plus randomized bench for q_bank_argmax against an array-based model.
module tb_q_bank_argmax;

  localparam int unsigned QW = 16;
  localparam int unsigned NA = 4;
  localparam int unsigned NR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_bank_argmax_if #(.Q_WIDTH(QW), .N_ACTIONS(NA), .N_ROADS(NR)) bus ();

  q_bank_argmax #(.Q_WIDTH(QW), .N_ACTIONS(NA), .N_ROADS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int model [NR][NA];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] exp_flat();
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < NR; r++)
      for (int a = 0; a < NA; a++) v[(r * NA + a) * QW +: QW] = 16'(model[r][a]);
    return v;
  endfunction

  // Maximum first, then the lowest action holding it.
  task automatic ref_max(input int r, output logic [15:0] m, output logic [1:0] idx);
    int best;
    best = model[r][0];
    for (int a = 1; a < NA; a++) if (model[r][a] > best) best = model[r][a];
    idx = '0;
    for (int a = NA - 1; a >= 0; a--) if (model[r][a] == best) idx = 2'(a);
    m = 16'(best);
  endtask

  function automatic logic [63:0] pack4(input int v0, input int v1, input int v2, input int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  task automatic write_row(input int r, input int v0, input int v1, input int v2, input int v3);
    int n;
    n = 0;
    while (!bus.wr_ready && n < 50) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", bus.wr_ready, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_road  = 2'(r);
    bus.wr_data  = pack4(v0, v1, v2, v3);
    tick();
    bus.wr_valid = 1'b0;
    model[r][0] = v0; model[r][1] = v1; model[r][2] = v2; model[r][3] = v3;
  endtask

  // Start at edge k, then follow edges k..k+NA+1 checking busy/done timing and result.
  task automatic do_scan(input int r, input string tag);
    logic [15:0] em;
    logic [1:0]  ei;
    ref_max(r, em, ei);
    bus.start     = 1'b1;
    bus.scan_road = 2'(r);
    tick();
    bus.start = 1'b0;
    for (int j = 0; j <= NA + 1; j++) begin
      if (j > 0) tick();
      chk({tag, ".busy"}, bus.busy, (j <= NA));
      chk({tag, ".done"}, bus.done, (j == NA));
      if (j >= NA) begin
        chk({tag, ".max_q"}, bus.max_q, em);
        chk({tag, ".max_action"}, bus.max_action, ei);
      end
    end
  endtask

  initial begin
    logic [15:0] em;
    logic [1:0]  ei;
    logic [255:0] old_flat;
    int done_cnt;
    int v [4];

    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_road = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.scan_road = '0;
    for (int r = 0; r < NR; r++) for (int a = 0; a < NA; a++) model[r][a] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst.q_flat", bus.q_flat, '0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.max_q", bus.max_q, 16'd0);
    chk("rst.max_action", bus.max_action, 2'd0);
    chk("rst.wr_ready", bus.wr_ready, 1'b1);

    // Basic row write and scan.
    write_row(2, 5, -3, 40, 12);
    chk("w2.q_flat", bus.q_flat, exp_flat());
    chk("w2.slice", bus.q_flat[(8 + 2) * 16 +: 16], 16'd40);
    do_scan(2, "scan2");

    // Negative values with a tie: lowest index wins.
    write_row(0, -7, -2, -2, -9);
    do_scan(0, "tie0");
    chk("tie0.value", bus.max_q, 16'hFFFE);

    // Write held during a scan, plus an ignored second start.
    ref_max(2, em, ei);
    old_flat = exp_flat();
    bus.start = 1'b1;
    bus.scan_road = 2'd2;
    tick();
    bus.scan_road = 2'd0;
    chk("wds.ready0", bus.wr_ready, 1'b0);
    done_cnt = 0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 1) begin
        bus.wr_valid = 1'b1;
        bus.wr_road  = 2'd1;
        bus.wr_data  = pack4(1, 1, 1, 1);
      end
      if (j == 6) begin
        bus.wr_valid = 1'b0;
        for (int a = 0; a < NA; a++) model[1][a] = 1;
      end
      if (bus.done) done_cnt++;
      chk("wds.wr_ready", bus.wr_ready, (j >= 5));
      chk("wds.done", bus.done, (j == 4));
      chk("wds.q_flat", bus.q_flat, (j >= 6) ? exp_flat() : old_flat);
      if (j == 4) begin
        chk("wds.max_q", bus.max_q, em);
        chk("wds.max_action", bus.max_action, ei);
      end
      if (j == 3) bus.start = 1'b0;
    end
    chk("wds.single_done", done_cnt, 1);
    chk("wds.idle", bus.busy, 1'b0);
    do_scan(1, "scan1");

    // Same-edge write and start: the scan must see the new row.
    bus.wr_valid  = 1'b1;
    bus.wr_road   = 2'd3;
    bus.wr_data   = pack4(0, 0, 0, 100);
    model[3][0] = 0; model[3][1] = 0; model[3][2] = 0; model[3][3] = 100;
    do_scan(3, "same_edge");
    bus.wr_valid = 1'b0;
    chk("same_edge.q", bus.max_q, 16'd100);
    chk("same_edge.a", bus.max_action, 2'd3);

    // Randomized rows, small ranges give frequent ties.
    for (int it = 0; it < 20; it++) begin
      int r;
      r = int'($urandom_range(0, NR - 1));
      for (int a = 0; a < 4; a++) begin
        if (it % 2 == 0) v[a] = int'($urandom_range(0, 6)) - 3;
        else v[a] = int'($signed(16'($urandom)));
      end
      write_row(r, v[0], v[1], v[2], v[3]);
      chk("rnd.q_flat", bus.q_flat, exp_flat());
      do_scan(int'($urandom_range(0, NR - 1)), "rnd");
    end

    // Reset in the middle of a scan.
    bus.start = 1'b1;
    bus.scan_road = 2'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    for (int r = 0; r < NR; r++) for (int a = 0; a < NA; a++) model[r][a] = 0;
    chk("mrst.busy", bus.busy, 1'b0);
    chk("mrst.done", bus.done, 1'b0);
    chk("mrst.q_flat", bus.q_flat, '0);
    chk("mrst.max_q", bus.max_q, 16'd0);
    chk("mrst.max_action", bus.max_action, 2'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("mrst.no_done", bus.done, 1'b0);
    end
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("mrst.after_done", bus.done, 1'b0);
    end
    do_scan(1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
